// File: rtl/sc_ctrl_pkg.sv
// Shared types and defaults for the stochastic-computing count controller.
package sc_ctrl_pkg;

  localparam int unsigned LEN_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } sc_state_e;

endpackage

// File: rtl/sc_counter.sv
// Bitstream ones-counter: preloads on init, adds bit_in on each enabled cycle.
`include "sys_defs.svh"

module sc_counter #(
  parameter int unsigned W = `OUT_BIN_LEN
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         init,
  input  logic [W-1:0] init_val,
  input  logic         enable,
  input  logic         bit_in,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count <= '0;
    end else if (init) begin
      r_count <= init_val;
    end else if (enable) begin
      r_count <= r_count + W'(bit_in);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/sys_defs.svh
// Shared system-wide widths for the stochastic-computing datapath.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH

`define OUT_BIN_LEN 8

`endif

// File: rtl/sc_count_ctrl.sv
// Job controller for a bitstream counter: preload, stream L cycles, capture, hand off.
`include "sys_defs.svh"

module sc_count_ctrl
  import sc_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [LEN_W-1:0]        stream_len,
  input  logic [`OUT_BIN_LEN-1:0] start_init_val,
  input  logic                    chain,
  input  logic                    abort,
  output logic                    cnt_init,
  output logic                    cnt_enable,
  output logic [`OUT_BIN_LEN-1:0] cnt_init_val,
  input  logic [`OUT_BIN_LEN-1:0] cnt_value,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [`OUT_BIN_LEN-1:0] result_data,
  output logic                    busy
);

  sc_state_e               r_state;
  logic [LEN_W-1:0]        r_len;
  logic [LEN_W-1:0]        r_remain;
  logic [`OUT_BIN_LEN-1:0] r_init_val;
  logic                    r_chain;
  logic                    r_start_ready;
  logic                    r_busy;
  logic                    r_cnt_init;
  logic                    r_cnt_enable;
  logic                    r_result_valid;
  logic [`OUT_BIN_LEN-1:0] r_result_data;
  logic                    w_chain_unused;

  // Chain routing uses the live input at the handshake; the latched copy is kept for debug visibility only.
  assign w_chain_unused = r_chain;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_len          <= '0;
      r_remain       <= '0;
      r_init_val     <= '0;
      r_chain        <= 1'b0;
      r_start_ready  <= 1'b1;
      r_busy         <= 1'b0;
      r_cnt_init     <= 1'b0;
      r_cnt_enable   <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_data  <= '0;
    end else if (abort && (r_state != S_IDLE)) begin
      r_state        <= S_IDLE;
      r_remain       <= '0;
      r_start_ready  <= 1'b1;
      r_busy         <= 1'b0;
      r_cnt_init     <= 1'b0;
      r_cnt_enable   <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid && r_start_ready) begin
            r_len         <= stream_len;
            r_init_val    <= start_init_val;
            r_chain       <= chain;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
            if (!chain) begin
              r_state    <= S_INIT;
              r_cnt_init <= 1'b1;
            end else if (stream_len == '0) begin
              r_state <= S_DRAIN;
            end else begin
              r_state      <= S_STREAM;
              r_cnt_enable <= 1'b1;
              r_remain     <= stream_len;
            end
          end
        end

        S_INIT: begin
          r_cnt_init <= 1'b0;
          if (r_len == '0) begin
            r_state <= S_DRAIN;
          end else begin
            r_state      <= S_STREAM;
            r_cnt_enable <= 1'b1;
            r_remain     <= r_len;
          end
        end

        // Remaining count of 1 marks the last enable cycle, so a full-scale length never wraps.
        S_STREAM: begin
          r_remain <= r_remain - LEN_W'(1);
          if (r_remain == LEN_W'(1)) begin
            r_state      <= S_DRAIN;
            r_cnt_enable <= 1'b0;
          end
        end

        S_DRAIN: begin
          r_result_data  <= cnt_value;
          r_result_valid <= 1'b1;
          r_state        <= S_DONE;
        end

        S_DONE: begin
          if (result_ready) begin
            r_result_valid <= 1'b0;
            r_start_ready  <= 1'b1;
            r_busy         <= 1'b0;
            r_state        <= S_IDLE;
          end
        end

        default: begin
          r_state        <= S_IDLE;
          r_start_ready  <= 1'b1;
          r_busy         <= 1'b0;
          r_cnt_init     <= 1'b0;
          r_cnt_enable   <= 1'b0;
          r_result_valid <= 1'b0;
        end
      endcase
    end
  end

  assign start_ready  = r_start_ready;
  assign busy         = r_busy;
  assign cnt_init     = r_cnt_init;
  assign cnt_enable   = r_cnt_enable;
  assign cnt_init_val = r_cnt_init ? r_init_val : '0;
  assign result_valid = r_result_valid;
  assign result_data  = r_result_data;

endmodule
